// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle for the 7-segment scan driver: write strobe, digit data and masks in,
// drive lines and status out.
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] codes;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   dig_en;
   logic                    pending;
   logic                    frame_done;

   modport master (
      output load, codes, blank_mask, blink_mask,
      input  seg, dig_en, pending, frame_done
   );

   modport slave (
      input  load, codes, blank_mask, blink_mask,
      output seg, dig_en, pending, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver with dead-time anti-ghosting, per-digit blank/blink
// and a double-buffered display image that only changes at frame boundaries.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEAD_CYCLES    = 500,
   parameter int BLINK_FRAMES   = 100,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input logic              clk,
   input logic              reset,
   seg7_scan_driver_if.slave bus
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] DEAD_START = DIV_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

   localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

   logic [DIV_W-1:0]        div_q, div_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [FRM_W-1:0]        frameCnt_q, frameCnt_d;
   logic                    blinkPhase_q, blinkPhase_d;
   logic [4*NUM_DIGITS-1:0] actCodes_q, actCodes_d, pendCodes_q, pendCodes_d;
   logic [NUM_DIGITS-1:0]   actBlank_q, actBlank_d, pendBlank_q, pendBlank_d;
   logic [NUM_DIGITS-1:0]   actBlink_q, actBlink_d, pendBlink_q, pendBlink_d;
   logic                    pending_q, pending_d;
   logic                    frameDone_q, frameDone_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   digEn_q, digEn_d;

   logic                    slotEnd, frameEnd;
   logic [3:0]              curCode;
   logic                    digitDark, digitLit;
   logic [NUM_DIGITS-1:0]   litMask;
   logic [6:0]              segRaw;

   function automatic logic [6:0] hexToSeg(input logic [3:0] value);
      logic [6:0] pattern;
      case (value)
         4'h0: pattern = 7'h7E;
         4'h1: pattern = 7'h30;
         4'h2: pattern = 7'h6D;
         4'h3: pattern = 7'h79;
         4'h4: pattern = 7'h33;
         4'h5: pattern = 7'h5B;
         4'h6: pattern = 7'h5F;
         4'h7: pattern = 7'h70;
         4'h8: pattern = 7'h7F;
         4'h9: pattern = 7'h7B;
         4'hA: pattern = 7'h77;
         4'hB: pattern = 7'h1F;
         4'hC: pattern = 7'h4E;
         4'hD: pattern = 7'h3D;
         4'hE: pattern = 7'h4F;
         default: pattern = 7'h47;
      endcase
      return pattern;
   endfunction

   // Slot divider, digit index and the frame counter that paces the blink phase.
   always_comb begin
      slotEnd      = (div_q == DIV_LAST);
      frameEnd     = slotEnd && (idx_q == IDX_LAST);
      div_d        = slotEnd ? '0 : div_q + 1'b1;
      idx_d        = idx_q;
      frameCnt_d   = frameCnt_q;
      blinkPhase_d = blinkPhase_q;
      frameDone_d  = frameEnd;
      if (slotEnd) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (frameEnd) begin
         if (frameCnt_q == FRM_LAST) begin
            frameCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
         end else begin
            frameCnt_d = frameCnt_q + 1'b1;
         end
      end
   end

   // A load landing on the boundary cycle bypasses the pending buffer so it is never lost.
   always_comb begin
      actCodes_d  = actCodes_q;
      actBlank_d  = actBlank_q;
      actBlink_d  = actBlink_q;
      pendCodes_d = pendCodes_q;
      pendBlank_d = pendBlank_q;
      pendBlink_d = pendBlink_q;
      pending_d   = pending_q;
      if (frameEnd) begin
         pending_d = 1'b0;
         if (bus.load) begin
            actCodes_d = bus.codes;
            actBlank_d = bus.blank_mask;
            actBlink_d = bus.blink_mask;
         end else if (pending_q) begin
            actCodes_d = pendCodes_q;
            actBlank_d = pendBlank_q;
            actBlink_d = pendBlink_q;
         end
      end else if (bus.load) begin
         pendCodes_d = bus.codes;
         pendBlank_d = bus.blank_mask;
         pendBlink_d = bus.blink_mask;
         pending_d   = 1'b1;
      end
   end

   always_comb begin
      curCode   = actCodes_q[{idx_q, 2'b00} +: 4];
      digitDark = actBlank_q[idx_q] | (actBlink_q[idx_q] & blinkPhase_q);
      digitLit  = (div_q >= DEAD_START) && !digitDark;
      litMask   = '0;
      if (digitLit) begin
         litMask[idx_q] = 1'b1;
      end
      segRaw  = digitLit ? hexToSeg(curCode) : 7'h00;
      seg_d   = SEG_ACTIVE_LOW ? ~segRaw : segRaw;
      digEn_d = DIG_ACTIVE_LOW ? ~litMask : litMask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q        <= '0;
         idx_q        <= '0;
         frameCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
         actCodes_q   <= '0;
         actBlank_q   <= '0;
         actBlink_q   <= '0;
         pendCodes_q  <= '0;
         pendBlank_q  <= '0;
         pendBlink_q  <= '0;
         pending_q    <= 1'b0;
         frameDone_q  <= 1'b0;
         seg_q        <= SEG_OFF;
         digEn_q      <= DIG_OFF;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         frameCnt_q   <= frameCnt_d;
         blinkPhase_q <= blinkPhase_d;
         actCodes_q   <= actCodes_d;
         actBlank_q   <= actBlank_d;
         actBlink_q   <= actBlink_d;
         pendCodes_q  <= pendCodes_d;
         pendBlank_q  <= pendBlank_d;
         pendBlink_q  <= pendBlink_d;
         pending_q    <= pending_d;
         frameDone_q  <= frameDone_d;
         seg_q        <= seg_d;
         digEn_q      <= digEn_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dig_en     = digEn_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle model queues the expected outputs of every edge and a
// checker pops them; scenario tasks add targeted checks at known points of the scan.
module tb_seg7_scan_driver;

   localparam int ND    = 4;
   localparam int SD    = 8;
   localparam int DC    = 2;
   localparam int BF    = 2;
   localparam int FRAME = ND * SD;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] dig;
      logic       pend;
      logic       fd;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   exp_t sbq[$];
   int   m_cyc = 0;
   logic [15:0] m_actCodes = '0, m_pendCodes = '0;
   logic [3:0]  m_actBlank = '0, m_pendBlank = '0;
   logic [3:0]  m_actBlink = '0, m_pendBlink = '0;
   logic        m_pending  = 1'b0;
   logic [6:0]  hexSeg [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_driver #(
      .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: position in the scan is derived from the cycle count since reset.
   initial begin
      int   div, idx, ph;
      logic bnd, dark;
      exp_t e;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_cyc = 0;
            m_actCodes = '0; m_actBlank = '0; m_actBlink = '0;
            m_pendCodes = '0; m_pendBlank = '0; m_pendBlink = '0;
            m_pending = 1'b0;
            sbq.delete();
         end else begin
            div  = m_cyc % SD;
            idx  = (m_cyc / SD) % ND;
            ph   = (m_cyc / FRAME / BF) % 2;
            bnd  = ((m_cyc % FRAME) == FRAME - 1);
            dark = m_actBlank[idx] | (m_actBlink[idx] & (ph != 0));
            e.seg = 7'h7F;
            e.dig = 4'hF;
            if (div >= DC && !dark) begin
               e.dig[idx] = 1'b0;
               e.seg = ~hexSeg[m_actCodes[idx*4 +: 4]];
            end
            if (bus.load) begin
               if (bnd) begin
                  m_actCodes = bus.codes; m_actBlank = bus.blank_mask; m_actBlink = bus.blink_mask;
                  m_pending = 1'b0;
               end else begin
                  m_pendCodes = bus.codes; m_pendBlank = bus.blank_mask; m_pendBlink = bus.blink_mask;
                  m_pending = 1'b1;
               end
            end else if (bnd && m_pending) begin
               m_actCodes = m_pendCodes; m_actBlank = m_pendBlank; m_actBlink = m_pendBlink;
               m_pending = 1'b0;
            end
            e.pend = m_pending;
            e.fd   = bnd;
            sbq.push_back(e);
            m_cyc++;
         end
      end
   end

   // Scoreboard checker: every edge outside reset must match the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("[TB] FAIL scoreboard_empty at t=%0t", $time);
            end else begin
               e = sbq.pop_front();
               if ({bus.seg, bus.dig_en, bus.pending, bus.frame_done} !== e) begin
                  bad++;
                  $display("[TB] FAIL scoreboard cyc=%0d got seg=%h dig=%h pend=%b fd=%b exp seg=%h dig=%h pend=%b fd=%b",
                           m_cyc - 1, bus.seg, bus.dig_en, bus.pending, bus.frame_done,
                           e.seg, e.dig, e.pend, e.fd);
               end
            end
         end
      end
   end

   // Returns just after the edge whose pre-edge scan position was cycle k.
   task automatic waitCyc(input int k);
      int guard = 0;
      do begin
         @(posedge clk);
         #2;
         guard++;
      end while (m_cyc != k + 1 && guard < 500);
      if (m_cyc != k + 1) begin
         total++;
         bad++;
         $display("[TB] FAIL waitCyc_timeout got=%0d exp=%0d", m_cyc, k + 1);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      total += 4;
      if (bus.seg !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg got=%h exp=7f", bus.seg); end
      if (bus.dig_en !== 4'hF) begin bad++; $display("[TB] FAIL reset_dig got=%h exp=f", bus.dig_en); end
      if (bus.pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending got=%b exp=0", bus.pending); end
      if (bus.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_fd got=%b exp=0", bus.frame_done); end
   endtask

   task automatic test_scan_timing();
      @(negedge clk);
      reset = 1'b0;
      bus.codes = 16'h3210;
      bus.load = 1'b1;
      waitCyc(0);
      bus.load = 1'b0;
      total++;
      if (bus.pending !== 1'b1) begin bad++; $display("[TB] FAIL t2_pending got=%b exp=1", bus.pending); end
      waitCyc(31);
      total += 2;
      if (bus.frame_done !== 1'b1) begin bad++; $display("[TB] FAIL t2_fd_first got=%b exp=1", bus.frame_done); end
      if (bus.pending !== 1'b0) begin bad++; $display("[TB] FAIL t2_commit got=%b exp=0", bus.pending); end
      waitCyc(32);
      total++;
      if (bus.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL t2_fd_pulse got=%b exp=0", bus.frame_done); end
      waitCyc(33);
      total++;
      if (bus.dig_en !== 4'hF) begin bad++; $display("[TB] FAIL t2_dead got=%h exp=f", bus.dig_en); end
      waitCyc(34);
      total++;
      if (bus.dig_en !== 4'hE) begin bad++; $display("[TB] FAIL t2_first_on got=%h exp=e", bus.dig_en); end
      waitCyc(39);
      total++;
      if (bus.dig_en !== 4'hE) begin bad++; $display("[TB] FAIL t2_last_on got=%h exp=e", bus.dig_en); end
      waitCyc(40);
      total++;
      if (bus.dig_en !== 4'hF) begin bad++; $display("[TB] FAIL t2_next_dead got=%h exp=f", bus.dig_en); end
      waitCyc(50);
      total += 2;
      if (bus.seg !== 7'h12) begin bad++; $display("[TB] FAIL t2_digit2_seg got=%h exp=12", bus.seg); end
      if (bus.dig_en !== 4'hB) begin bad++; $display("[TB] FAIL t2_digit2_dig got=%h exp=b", bus.dig_en); end
      waitCyc(63);
      total++;
      if (bus.frame_done !== 1'b1) begin bad++; $display("[TB] FAIL t2_fd_second got=%b exp=1", bus.frame_done); end
   endtask

   task automatic test_tear_free();
      int f = (m_cyc / FRAME + 1) * FRAME;
      waitCyc(f + 9);
      bus.codes = 16'h1234;
      bus.load = 1'b1;
      waitCyc(f + 10);
      bus.load = 1'b0;
      total++;
      if (bus.pending !== 1'b1) begin bad++; $display("[TB] FAIL t3_pending got=%b exp=1", bus.pending); end
      waitCyc(f + 19);
      bus.codes = 16'hABCD;
      bus.load = 1'b1;
      waitCyc(f + 20);
      bus.load = 1'b0;
      waitCyc(f + 26);
      total++;
      if (bus.seg !== 7'h06) begin bad++; $display("[TB] FAIL t3_unchanged got=%h exp=06", bus.seg); end
      waitCyc(f + 30);
      total++;
      if (bus.pending !== 1'b1) begin bad++; $display("[TB] FAIL t3_still_pending got=%b exp=1", bus.pending); end
      waitCyc(f + 31);
      total++;
      if (bus.pending !== 1'b0) begin bad++; $display("[TB] FAIL t3_committed got=%b exp=0", bus.pending); end
      waitCyc(f + 34);
      total += 2;
      if (bus.seg !== 7'h42) begin bad++; $display("[TB] FAIL t3_last_wins got=%h exp=42", bus.seg); end
      if (bus.dig_en !== 4'hE) begin bad++; $display("[TB] FAIL t3_dig got=%h exp=e", bus.dig_en); end
   endtask

   task automatic test_blank_blink();
      int f = (m_cyc / FRAME + 1) * FRAME;
      int g;
      logic dark;
      waitCyc(f + 9);
      bus.codes = 16'hABCD;
      bus.blank_mask = 4'b0001;
      bus.blink_mask = 4'b0010;
      bus.load = 1'b1;
      waitCyc(f + 10);
      bus.load = 1'b0;
      for (int fr = f / FRAME + 1; fr <= f / FRAME + 8; fr++) begin
         g = fr * FRAME;
         dark = ((fr / BF) % 2) != 0;
         waitCyc(g + 2);
         total++;
         if (bus.dig_en[0] !== 1'b1) begin bad++; $display("[TB] FAIL t4_blank frame=%0d got=%b exp=1", fr, bus.dig_en[0]); end
         waitCyc(g + SD + 2);
         total += 2;
         if (bus.dig_en[1] !== dark) begin bad++; $display("[TB] FAIL t4_blink_dig frame=%0d got=%b exp=%b", fr, bus.dig_en[1], dark); end
         if (bus.seg !== (dark ? 7'h7F : 7'h31)) begin
            bad++;
            $display("[TB] FAIL t4_blink_seg frame=%0d got=%h exp=%h", fr, bus.seg, dark ? 7'h7F : 7'h31);
         end
      end
   endtask

   task automatic test_boundary_load();
      int f = (m_cyc / FRAME + 1) * FRAME;
      waitCyc(f + 30);
      bus.codes = 16'h8E05;
      bus.blank_mask = 4'b0000;
      bus.blink_mask = 4'b0000;
      bus.load = 1'b1;
      waitCyc(f + 31);
      bus.load = 1'b0;
      total += 2;
      if (bus.pending !== 1'b0) begin bad++; $display("[TB] FAIL t5_no_pending got=%b exp=0", bus.pending); end
      if (bus.frame_done !== 1'b1) begin bad++; $display("[TB] FAIL t5_fd got=%b exp=1", bus.frame_done); end
      waitCyc(f + 34);
      total += 3;
      if (bus.seg !== 7'h24) begin bad++; $display("[TB] FAIL t5_digit0 got=%h exp=24", bus.seg); end
      if (bus.dig_en !== 4'hE) begin bad++; $display("[TB] FAIL t5_dig0 got=%h exp=e", bus.dig_en); end
      if (bus.pending !== 1'b0) begin bad++; $display("[TB] FAIL t5_pending_later got=%b exp=0", bus.pending); end
      waitCyc(f + 50);
      total += 2;
      if (bus.seg !== 7'h30) begin bad++; $display("[TB] FAIL t5_digit2 got=%h exp=30", bus.seg); end
      if (bus.dig_en !== 4'hB) begin bad++; $display("[TB] FAIL t5_dig2 got=%h exp=b", bus.dig_en); end
   endtask

   task automatic test_reset_mid_frame();
      int f = (m_cyc / FRAME + 1) * FRAME;
      waitCyc(f + 4);
      bus.codes = 16'h1111;
      bus.load = 1'b1;
      waitCyc(f + 5);
      bus.load = 1'b0;
      total++;
      if (bus.pending !== 1'b1) begin bad++; $display("[TB] FAIL t6_pending got=%b exp=1", bus.pending); end
      waitCyc(f + 20);
      total++;
      if (bus.dig_en !== 4'hB) begin bad++; $display("[TB] FAIL t6_before got=%h exp=b", bus.dig_en); end
      #1;
      reset = 1'b1;
      #1;
      total += 4;
      if (bus.seg !== 7'h7F) begin bad++; $display("[TB] FAIL t6_async_seg got=%h exp=7f", bus.seg); end
      if (bus.dig_en !== 4'hF) begin bad++; $display("[TB] FAIL t6_async_dig got=%h exp=f", bus.dig_en); end
      if (bus.pending !== 1'b0) begin bad++; $display("[TB] FAIL t6_async_pending got=%b exp=0", bus.pending); end
      if (bus.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL t6_async_fd got=%b exp=0", bus.frame_done); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      waitCyc(2);
      total += 2;
      if (bus.seg !== 7'h01) begin bad++; $display("[TB] FAIL t6_restart_seg got=%h exp=01", bus.seg); end
      if (bus.dig_en !== 4'hE) begin bad++; $display("[TB] FAIL t6_restart_dig got=%h exp=e", bus.dig_en); end
      waitCyc(34);
      total += 2;
      if (bus.seg !== 7'h01) begin bad++; $display("[TB] FAIL t6_cleared_seg got=%h exp=01", bus.seg); end
      if (bus.pending !== 1'b0) begin bad++; $display("[TB] FAIL t6_cleared_pending got=%b exp=0", bus.pending); end
   endtask

   initial begin
      bus.load = 1'b0;
      bus.codes = '0;
      bus.blank_mask = '0;
      bus.blink_mask = '0;
      test_reset();
      test_scan_timing();
      test_tear_free();
      test_blank_blink();
      test_boundary_load();
      test_reset_mid_frame();
      repeat (3) @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
